// File: rtl/dmem_responder_if.sv
// Request/response channel bundle between the core data port and dmem_responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind valid/ready request and response channels,
// with LATENCY wait states inserted between request acceptance and the access.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_req_err;
  logic                w_accept;
  logic                w_mem_we;

  assign w_req_err = (bus.req_addr[1:0] != 2'b00) ||
                     (bus.req_addr[31:ADDR_W+2] != '0);
  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;

  // rst gate keeps a store that coincides with reset from reaching the array
  assign w_mem_we  = (r_state == S_ACCESS) && r_we && !r_err && !rst;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_cnt_next = LAT4;
          w_next     = (LATENCY > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= bus.req_we;
      r_err   <= w_req_err;
      r_idx   <= bus.req_addr[ADDR_W+1:2];
      r_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      if (r_state == S_ACCESS) begin
        r_rdata      <= (!r_we && !r_err) ? r_mem[r_idx] : '0;
        r_resp_err   <= r_err;
        r_resp_valid <= 1'b1;
      end else if ((r_state == S_RESP) && bus.resp_ready) begin
        r_resp_valid <= 1'b0;
        r_resp_err   <= 1'b0;
      end
    end
  end

  // Array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule
